// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - opcode/done sequencer feeding game_plate (keys, gravity, lock sequence, line count)
// Optional score output is enabled with GAME_SEQ_SCORE_EN.
module game_sequencer #(
  parameter int height_p      = 20,
  parameter int grav_width_p  = 24,
  parameter int lines_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic                        key_left_i,
  input  logic                        key_right_i,
  input  logic                        key_down_i,
  input  logic                        key_rot_i,
  input  logic [grav_width_p-1:0]     gravity_period_i,
  output logic [2:0]                  opcode_o,
  output logic                        opcode_v_o,
  input  logic                        done_i,
  input  logic                        down_blocked_i,
  input  logic                        lose_i,
  input  logic [$clog2(height_p)-1:0] line_elim_i,
  input  logic                        line_elim_v_i,
  output logic                        busy_o,
  output logic                        playing_o,
  output logic                        game_over_o,
  output logic [lines_width_p-1:0]    lines_total_o
`ifdef GAME_SEQ_SCORE_EN
  ,
  output logic [23:0]                 score_o
`endif
);

  localparam int lines_sum_w_lp = lines_width_p + 1;
  localparam logic [grav_width_p-1:0] grav_one_lp = grav_width_p'(1);

  typedef enum logic [2:0] {
    eNop = 3'd0, eNew = 3'd1, eMoveLeft = 3'd2, eMoveRight = 3'd3,
    eMoveDown = 3'd4, eRotate = 3'd5, eCommit = 3'd6, eCheck = 3'd7
  } opcode_e;
  typedef enum logic [2:0] {eIdle, eSel, eWait, eGap, eLost} state_e;
  typedef enum logic [1:0] {eLockNone, eLockCommit, eLockCheck, eLockNew} lock_e;

  state_e  state_q, state_d;
  lock_e   lock_q, lock_d;
  opcode_e opcode_q, opcode_d;
  logic    opcode_v_q, opcode_v_d;

  logic grav_pend_q, down_pend_q, left_pend_q, right_pend_q, rot_pend_q;
  logic grav_pend_d, down_pend_d, left_pend_d, right_pend_d, rot_pend_d;
  logic issue_grav, issue_down, issue_left, issue_right, issue_rot;
  logic new_game, playing, grav_run, grav_tick;

  logic [grav_width_p-1:0]   grav_cnt_q, grav_cnt_d;
  logic [lines_width_p-1:0]  lines_q, lines_d;
  logic [lines_sum_w_lp-1:0] lines_sum;

  assign playing  = (state_q == eSel) || (state_q == eWait) || (state_q == eGap);
  assign grav_run = playing && (lock_q == eLockNone);

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    opcode_d    = opcode_q;
    opcode_v_d  = 1'b0;
    new_game    = 1'b0;
    issue_grav  = 1'b0;
    issue_down  = 1'b0;
    issue_left  = 1'b0;
    issue_right = 1'b0;
    issue_rot   = 1'b0;
    case (state_q)
      eIdle, eLost: begin
        if (start_i) begin
          new_game   = 1'b1;
          state_d    = eWait;
          opcode_d   = eNew;
          opcode_v_d = 1'b1;
          lock_d     = eLockNone;
        end
      end
      eSel: begin
        if (lose_i) begin
          state_d = eLost;
        end else begin
          opcode_v_d = 1'b1;
          state_d    = eWait;
          // A lock step outranks everything; keys stay pending behind it.
          if (lock_q != eLockNone) begin
            case (lock_q)
              eLockCommit: opcode_d = eCommit;
              eLockCheck:  opcode_d = eCheck;
              default:     opcode_d = eNew;
            endcase
          end else if (grav_pend_q) begin
            opcode_d   = eMoveDown;
            issue_grav = 1'b1;
          end else if (down_pend_q) begin
            opcode_d   = eMoveDown;
            issue_down = 1'b1;
          end else if (left_pend_q) begin
            opcode_d   = eMoveLeft;
            issue_left = 1'b1;
          end else if (right_pend_q) begin
            opcode_d    = eMoveRight;
            issue_right = 1'b1;
          end else if (rot_pend_q) begin
            opcode_d  = eRotate;
            issue_rot = 1'b1;
          end else begin
            opcode_v_d = 1'b0;
            state_d    = eSel;
          end
        end
      end
      eWait: begin
        if (lose_i) begin
          state_d = eLost;
        end else if (done_i) begin
          state_d = eGap;
          case (opcode_q)
            eMoveDown: if (down_blocked_i) lock_d = eLockCommit;
            eCommit:   lock_d = eLockCheck;
            eCheck:    lock_d = eLockNew;
            eNew:      lock_d = eLockNone;
            default:   lock_d = lock_q;
          endcase
        end
      end
      eGap:    state_d = lose_i ? eLost : eSel;
      default: state_d = eIdle;
    endcase
  end

  // A period change below the running count restarts the count without a tick.
  always_comb begin
    grav_tick  = 1'b0;
    grav_cnt_d = grav_cnt_q;
    if (new_game) begin
      grav_cnt_d = '0;
    end else if (grav_run) begin
      if (gravity_period_i == '0) begin
        grav_cnt_d = '0;
      end else if (grav_cnt_q == gravity_period_i - grav_one_lp) begin
        grav_tick  = 1'b1;
        grav_cnt_d = '0;
      end else if (grav_cnt_q >= gravity_period_i) begin
        grav_cnt_d = '0;
      end else begin
        grav_cnt_d = grav_cnt_q + grav_one_lp;
      end
    end
  end

  always_comb begin
    grav_pend_d  = (grav_pend_q  & ~issue_grav)  | grav_tick;
    down_pend_d  = (down_pend_q  & ~issue_down)  | (key_down_i  & playing);
    left_pend_d  = (left_pend_q  & ~issue_left)  | (key_left_i  & playing);
    right_pend_d = (right_pend_q & ~issue_right) | (key_right_i & playing);
    rot_pend_d   = (rot_pend_q   & ~issue_rot)   | (key_rot_i   & playing);
    if (new_game) begin
      grav_pend_d  = 1'b0;
      down_pend_d  = 1'b0;
      left_pend_d  = 1'b0;
      right_pend_d = 1'b0;
      rot_pend_d   = 1'b0;
    end
  end

  assign lines_sum = {1'b0, lines_q} + lines_sum_w_lp'(line_elim_i);

  always_comb begin
    lines_d = lines_q;
    if (new_game) begin
      lines_d = '0;
    end else if (line_elim_v_i) begin
      lines_d = lines_sum[lines_width_p] ? '1 : lines_sum[lines_width_p-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= eIdle;
      lock_q       <= eLockNone;
      opcode_q     <= eNop;
      opcode_v_q   <= 1'b0;
      grav_pend_q  <= 1'b0;
      down_pend_q  <= 1'b0;
      left_pend_q  <= 1'b0;
      right_pend_q <= 1'b0;
      rot_pend_q   <= 1'b0;
      grav_cnt_q   <= '0;
      lines_q      <= '0;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      opcode_q     <= opcode_d;
      opcode_v_q   <= opcode_v_d;
      grav_pend_q  <= grav_pend_d;
      down_pend_q  <= down_pend_d;
      left_pend_q  <= left_pend_d;
      right_pend_q <= right_pend_d;
      rot_pend_q   <= rot_pend_d;
      grav_cnt_q   <= grav_cnt_d;
      lines_q      <= lines_d;
    end
  end

`ifdef GAME_SEQ_SCORE_EN
  localparam int elim_w_lp = $clog2(height_p);

  logic [23:0] score_q, score_d;
  logic [10:0] points;
  logic [24:0] score_sum;

  always_comb begin
    points = 11'd0;
    if (line_elim_i >= elim_w_lp'(4)) begin
      points = 11'd1200;
    end else begin
      case (line_elim_i[1:0])
        2'd0:    points = 11'd0;
        2'd1:    points = 11'd40;
        2'd2:    points = 11'd100;
        default: points = 11'd300;
      endcase
    end
  end

  assign score_sum = {1'b0, score_q} + 25'(points);

  always_comb begin
    score_d = score_q;
    if (new_game) begin
      score_d = '0;
    end else if (line_elim_v_i) begin
      score_d = score_sum[24] ? '1 : score_sum[23:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;
`endif

  assign opcode_o      = opcode_q;
  assign opcode_v_o    = opcode_v_q;
  assign busy_o        = (state_q == eWait);
  assign playing_o     = playing;
  assign game_over_o   = (state_q == eLost);
  assign lines_total_o = lines_q;

endmodule
